// File: rtl/craps_pkg.sv
// Shared types and constants for the craps round controller.
// Optional bankroll feature is enabled by defining CRAPS_BANKROLL_EN.
package craps_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ROLL_CO = 3'd1,
        POINT   = 3'd2,
        ROLL_PT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [3:0] SUM_SEVEN  = 4'd7;
    localparam logic [3:0] SUM_ELEVEN = 4'd11;
    localparam logic [7:0] BANK_INIT  = 8'd100;
    localparam logic [7:0] BANK_STEP  = 8'd10;

    function automatic logic is_craps(input logic [3:0] s);
        return (s == 4'd2) || (s == 4'd3) || (s == 4'd12);
    endfunction

    function automatic logic face_ok(input logic [2:0] f);
        return (f != 3'd0) && (f != 3'd7);
    endfunction

endpackage

// File: rtl/craps_edge_det.sv
// Rising-edge detector for the enter button; the history register resets high
// so a button held through reset release does not count as a press.
module craps_edge_det (
    input  logic gclk,
    input  logic grst_n,
    input  logic d,
    output logic pulse
);
    logic d_q;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) d_q <= 1'b1;
        else         d_q <= d;
    end

    assign pulse = d & ~d_q;
endmodule

// File: rtl/craps_round_ctrl.sv
// Craps round sequencer: come-out roll, point phase, ack timeout and error pulse.
// Define CRAPS_BANKROLL_EN to add the bank output and game-over press blocking.
module craps_round_ctrl
    import craps_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int ROLL_W      = 5
) (
    input  logic              clk_main,
    input  logic              reset,
    input  logic              enter,
    output logic              roll_req,
    input  logic              roll_ack,
    input  logic [2:0]        die1,
    input  logic [2:0]        die2,
    output logic              win,
    output logic              lose,
    output logic [3:0]        sum_out,
    output logic [3:0]        point,
    output logic [ROLL_W-1:0] rolls,
    output logic              err
`ifdef CRAPS_BANKROLL_EN
    ,
    output logic [7:0]        bank
`endif
);
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       press, press_ok, new_round;
    logic       gap_q, ack_ok, legal, illegal, timeout_fire;
    logic       win_set, lose_set, point_set;
    logic [7:0] wait_cnt;
    logic [3:0] sum;

    craps_edge_det u_edge (
        .gclk  (clk_main),
        .grst_n(reset),
        .d     (enter),
        .pulse (press)
    );

`ifdef CRAPS_BANKROLL_EN
    assign press_ok = press & (bank != 8'd0);
`else
    assign press_ok = press;
`endif

    // Request is a pure function of state, so an async reset drops it at once.
    assign roll_req     = ((state == ROLL_CO) || (state == ROLL_PT)) && !gap_q;
    assign ack_ok       = roll_req & roll_ack;
    assign legal        = ack_ok & face_ok(die1) & face_ok(die2);
    assign illegal      = ack_ok & ~(face_ok(die1) & face_ok(die2));
    assign sum          = {1'b0, die1} + {1'b0, die2};
    assign timeout_fire = roll_req & ~roll_ack & (wait_cnt == TO_LAST);
    assign new_round    = ((state == IDLE) || (state == DONE)) & press_ok;

    always_comb begin
        state_nxt = state;
        win_set   = 1'b0;
        lose_set  = 1'b0;
        point_set = 1'b0;
        case (state)
            IDLE, DONE: if (press_ok) state_nxt = ROLL_CO;
            POINT:      if (press)    state_nxt = ROLL_PT;
            ROLL_CO: if (legal) begin
                if ((sum == SUM_SEVEN) || (sum == SUM_ELEVEN)) begin
                    win_set   = 1'b1;
                    state_nxt = DONE;
                end else if (is_craps(sum)) begin
                    lose_set  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    point_set = 1'b1;
                    state_nxt = POINT;
                end
            end
            ROLL_PT: if (legal) begin
                if (sum == point) begin
                    win_set   = 1'b1;
                    state_nxt = DONE;
                end else if (sum == SUM_SEVEN) begin
                    lose_set  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = POINT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gap_q    <= 1'b0;
            wait_cnt <= '0;
            err      <= 1'b0;
            win      <= 1'b0;
            lose     <= 1'b0;
            sum_out  <= '0;
            point    <= '0;
            rolls    <= '0;
        end else begin
            state    <= state_nxt;
            gap_q    <= timeout_fire;
            err      <= illegal | timeout_fire;
            wait_cnt <= (roll_req & ~roll_ack & ~timeout_fire) ? wait_cnt + 8'd1 : 8'd0;
            if (new_round) begin
                win   <= 1'b0;
                lose  <= 1'b0;
                point <= '0;
                rolls <= '0;
            end
            if (legal) begin
                sum_out <= sum;
                if (rolls != {ROLL_W{1'b1}}) rolls <= rolls + ROLL_W'(1);
            end
            if (win_set)   win   <= 1'b1;
            if (lose_set)  lose  <= 1'b1;
            if (point_set) point <= sum;
        end
    end

`ifdef CRAPS_BANKROLL_EN
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            bank <= BANK_INIT;
        end else if (win_set) begin
            bank <= (bank > 8'd255 - BANK_STEP) ? 8'd255 : bank + BANK_STEP;
        end else if (lose_set) begin
            bank <= (bank < BANK_STEP) ? 8'd0 : bank - BANK_STEP;
        end
    end
`endif

endmodule

// File: tb/tb_craps_round_ctrl.sv
// Directed bench for craps_round_ctrl; expected roll results go through a scoreboard queue.
// Bank checks are compiled in when CRAPS_BANKROLL_EN is defined.
module tb_craps_round_ctrl;
    logic       clk_main = 1'b0;
    logic       reset    = 1'b0;
    logic       enter    = 1'b0;
    logic       roll_ack = 1'b0;
    logic [2:0] die1     = 3'd0;
    logic [2:0] die2     = 3'd0;
    logic       roll_req, win, lose, err;
    logic [3:0] sum_out, point;
    logic [4:0] rolls;
`ifdef CRAPS_BANKROLL_EN
    logic [7:0] bank;
`endif

    typedef struct {
        logic [3:0] sum;
        logic       win;
        logic       lose;
        logic [3:0] point;
        logic [4:0] rolls;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    craps_round_ctrl #(.ACK_TIMEOUT(15), .ROLL_W(5)) dut (
        .clk_main(clk_main),
        .reset   (reset),
        .enter   (enter),
        .roll_req(roll_req),
        .roll_ack(roll_ack),
        .die1    (die1),
        .die2    (die2),
        .win     (win),
        .lose    (lose),
        .sum_out (sum_out),
        .point   (point),
        .rolls   (rolls),
        .err     (err)
`ifdef CRAPS_BANKROLL_EN
        ,
        .bank    (bank)
`endif
    );

    always #5 clk_main = ~clk_main;

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic w, input logic l,
                        input logic [3:0] p, input logic [4:0] r, input logic e);
        exp_t x;
        x.sum = s; x.win = w; x.lose = l; x.point = p; x.rolls = r; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic press_btn(input string tag);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        chk({tag, "_req"}, roll_req, 1);
    endtask

    task automatic do_roll(input logic [2:0] a, input logic [2:0] b, input string tag);
        exp_t e;
        int   n = 0;
        while (roll_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_wait"}, roll_req, 1);
        die1 = a; die2 = b; roll_ack = 1'b1;
        tick();
        roll_ack = 1'b0; die1 = 3'd0; die2 = 3'd0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb no expected entry queued", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"},   sum_out, e.sum);
            chk({tag, "_win"},   win,     e.win);
            chk({tag, "_lose"},  lose,    e.lose);
            chk({tag, "_point"}, point,   e.point);
            chk({tag, "_rolls"}, rolls,   e.rolls);
            chk({tag, "_err"},   err,     e.err);
        end
    endtask

    initial begin
        int n;
        // reset state, with enter held across release
        tick(); tick();
        chk("rst_req", roll_req, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_point", point, 0);
        chk("rst_rolls", rolls, 0);
        chk("rst_err", err, 0);
        enter = 1'b1;
        reset = 1'b1;
        tick(); tick();
        chk("held_enter_no_press", roll_req, 0);
        enter = 1'b0;
        tick();

        // come-out win
        press_btn("t1");
        push(4'd7, 1, 0, 4'd0, 5'd1, 0);
        do_roll(3'd3, 3'd4, "t1");
        chk("t1_req_drop", roll_req, 0);
        roll_ack = 1'b1; die1 = 3'd6; die2 = 3'd6;
        tick();
        roll_ack = 1'b0;
        chk("stray_ack_sum", sum_out, 7);
        chk("stray_ack_win", win, 1);

        // come-out craps, then next round clears outcome
        press_btn("t2");
        chk("t2_clr_win", win, 0);
        push(4'd12, 0, 1, 4'd0, 5'd1, 0);
        do_roll(3'd6, 3'd6, "t2");
        press_btn("t3a");
        chk("t3_clr_lose", lose, 0);
        chk("t3_clr_rolls", rolls, 0);

        // point made
        push(4'd5, 0, 0, 4'd5, 5'd1, 0);
        do_roll(3'd2, 3'd3, "t3a");
        chk("t3_point_idle_req", roll_req, 0);
        press_btn("t3b");
        push(4'd8, 0, 0, 4'd5, 5'd2, 0);
        do_roll(3'd4, 3'd4, "t3b");
        press_btn("t3c");
        push(4'd5, 1, 0, 4'd5, 5'd3, 0);
        do_roll(3'd1, 3'd4, "t3c");

        // seven-out
        press_btn("t4a");
        push(4'd6, 0, 0, 4'd6, 5'd1, 0);
        do_roll(3'd2, 3'd4, "t4a");
        press_btn("t4b");
        push(4'd7, 0, 1, 4'd6, 5'd2, 0);
        do_roll(3'd3, 3'd4, "t4b");

        // illegal face, then ack timeout
        press_btn("t5");
        push(4'd7, 0, 0, 4'd0, 5'd0, 1);
        do_roll(3'd0, 3'd3, "t5_bad");
        chk("t5_rereq", roll_req, 1);
        n = 0;
        while (roll_req === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 15);
        chk("to_err", err, 1);
        tick();
        chk("to_rereq", roll_req, 1);
        chk("to_err_clr", err, 0);
        push(4'd10, 0, 0, 4'd10, 5'd1, 0);
        do_roll(3'd5, 3'd5, "t5_ok");

        // rolls saturation in point phase
        for (int i = 0; i < 31; i++) begin
            press_btn("sat");
            push(4'd6, 0, 0, 4'd10, (i + 2 > 31) ? 5'd31 : 5'(i + 2), 0);
            do_roll(3'd3, 3'd3, "sat");
        end

        // reset mid-roll, ack pending across release
        press_btn("t6");
        reset = 1'b0;
        #1;
        chk("t6_req", roll_req, 0);
        chk("t6_point", point, 0);
        chk("t6_rolls", rolls, 0);
        chk("t6_sum", sum_out, 0);
        roll_ack = 1'b1; die1 = 3'd3; die2 = 3'd4;
        tick();
        reset = 1'b1;
        tick(); tick();
        roll_ack = 1'b0;
        chk("t6_ack_ign_sum", sum_out, 0);
        chk("t6_ack_ign_win", win, 0);
        chk("t6_idle_req", roll_req, 0);

`ifdef CRAPS_BANKROLL_EN
        chk("bank_init", bank, 100);
        for (int i = 0; i < 10; i++) begin
            press_btn("bank");
            push(4'd2, 0, 1, 4'd0, 5'd1, 0);
            do_roll(3'd1, 3'd1, "bank");
            chk("bank_val", bank, 100 - 10 * (i + 1));
        end
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        chk("bank_blocked", roll_req, 0);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
